// File: rtl/bibuf_bus_ctrl.sv
// Registered bidirectional pad bank with sequenced direction control: write drive with
// hold, all-released turnaround dead time, and synchronised read capture from the pads.
module bibuf_bus_ctrl #(
    parameter int              WIDTH        = 16,
    parameter string           IOSTD        = "LVCMOS25",
    parameter logic [WIDTH-1:0] OE_MASK     = {WIDTH{1'b1}},
    parameter int              DRIVE_CYCLES = 1,
    parameter int              TURN_CYCLES  = 1,
    parameter int              SYNC_STAGES  = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    inout  wire  [WIDTH-1:0] PAD_BI,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy
);

    localparam int MAX_CNT = (DRIVE_CYCLES > TURN_CYCLES)
                           ? ((DRIVE_CYCLES > SYNC_STAGES) ? DRIVE_CYCLES : SYNC_STAGES)
                           : ((TURN_CYCLES  > SYNC_STAGES) ? TURN_CYCLES  : SYNC_STAGES);
    localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LD = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LD  = CNT_W'(SYNC_STAGES - 1);

    if (WIDTH < 1 || WIDTH > 32 || DRIVE_CYCLES < 1 || TURN_CYCLES < 1 ||
        SYNC_STAGES < 1 || IOSTD == "") begin : g_param_err
        $error("bibuf_bus_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, DRIVE, TURN, SAMPLE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] oe_reg, oe_nxt;
    logic [WIDTH-1:0] pad_e;
    logic [WIDTH-1:0] pad_y;
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic             load_wr;
    logic             capture;

    // Per-bit BIBUF: E gated by the drive mask so input-only bits can never drive
    assign pad_e = oe_reg & OE_MASK;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bibuf
        assign PAD_BI[i] = pad_e[i] ? out_reg[i] : 1'bz;
    end
    assign pad_y = PAD_BI;

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        oe_nxt    = oe_reg;
        load_wr   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    load_wr   = 1'b1;
                    oe_nxt    = OE_MASK;
                    state_nxt = DRIVE;
                    cnt_nxt   = DRIVE_LD;
                end else if (rd_req) begin
                    oe_nxt    = '0;
                    state_nxt = SAMPLE;
                    cnt_nxt   = SYNC_LD;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    oe_nxt    = '0;
                    state_nxt = TURN;
                    cnt_nxt   = TURN_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            TURN: begin
                oe_nxt = '0;
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            SAMPLE: begin
                oe_nxt = '0;
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                oe_nxt    = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered state, pad drive, free-running receive synchroniser and read capture
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            cnt      <= '0;
            out_reg  <= '0;
            oe_reg   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            oe_reg   <= oe_nxt;
            rd_valid <= capture;
            if (load_wr) out_reg <= wr_data;
            if (capture) rd_data <= sync_p[SYNC_STAGES-1];
            sync_p[0] <= pad_y;
            for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
        end
    end

endmodule
